mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 2:1 datapath mux (in1/in2/sel/out) between two valid/ready requesters.
- Sequences the mux select from a registered grant state machine.
- Owns a single-stage registered output with valid/ready toward the downstream consumer.
- Sits between two producer channels and one shared 32-bit bus; bounds each grant by a burst limit so neither requester can starve the other.

Parameters:
- WIDTH, 32, data width of in1/in2/out.
- MAX_BURST, 4, maximum consecutive transfers per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in1  input  WIDTH  requester 1 data
- in1_valid  input  1  requester 1 has data
- in1_ready  output  1  arbiter accepts in1 this cycle
- in2  input  WIDTH  requester 2 data
- in2_valid  input  1  requester 2 has data
- in2_ready  output  1  arbiter accepts in2 this cycle
- sel  output  1  mux select: 0 = in1, 1 = in2; registered, follows grant state
- out  output  WIDTH  registered shared-bus data
- out_valid  output  1  out holds untaken data
- out_ready  input  1  downstream accepts out

Behaviour:
- Reset: rst_n sampled low at a clk edge gives:
  - state=IDLE, sel=0, out=0, out_valid=0, burst_cnt=0;
  - last_winner=2, so in1 wins the first tie.
  - in1_ready and in2_ready are 0 whenever state=IDLE; in reset they are 0 because state is forced to IDLE.
  - Reset mid-burst discards any buffered out word; there is no replay.
- States:
  - IDLE: no grant.
  - G1: in1 granted, sel=0.
  - G2: in2 granted, sel=1.
- Output slot:
  - free = !out_valid || out_ready.
  - in1_ready = (state==G1) && free; in2_ready = (state==G2) && free. Both are combinational from registered state and out_valid/out_ready.
  - Transfer occurs when granted valid && ready. On a transfer, next cycle out = granted data, out_valid=1.
  - If out_valid && out_ready with no transfer, next cycle out_valid=0 and out holds its last value.
  - out and out_valid are held stable while out_valid && !out_ready.
  - Never both readies high; at most one word is accepted per cycle.
- Round-robin pick (used by the transitions below):
  - both valid: grant the requester != last_winner;
  - one valid: grant it;
  - none valid: IDLE.
- IDLE:
  - Pick as above.
  - Grant takes effect next cycle; burst_cnt=0 on entry.
  - Request latency: valid high in IDLE at cycle N, ready at N+1 if the slot is free, out_valid at N+2.
- G1 (G2 symmetric):
  - Transfer with burst_cnt+1 < MAX_BURST: stay in G1, burst_cnt++.
  - Transfer with burst_cnt+1 == MAX_BURST: last_winner=1 and burst_cnt=0. If in2_valid go to G2, else stay in G1 (re-grant, no bubble).
  - in1_valid low: last_winner=1, burst_cnt=0, re-pick from current valids. This can land directly in G2 or IDLE, or in G1 if in1_valid only.
  - in1_valid high but stalled (no ready): hold state and burst_cnt.
- burst_cnt width: clog2(MAX_BURST+1). MAX_BURST=1 gives strict per-word alternation under contention.
- Throughput: 1 word/cycle with out_ready=1 and a continuous single requester. A grant switch caused by burst expiry costs no bubble.
- Requester contract: valid held with stable data until ready. A requester dropping valid without a transfer is legal and releases the grant.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with both valids high -> out=0x00000000, out_valid=0, sel=0, in1_ready=in2_ready=0. After release, first grant is to in1 (G1).
2. Single request: in1=0x00000001, in1_valid=1 at cycle N, out_ready=1 -> in1_ready=1 at N+1, out=0x00000001 with out_valid=1 and sel=0 at N+2. Drop valid -> state returns to IDLE, out_valid clears.
3. Contention, MAX_BURST=4, out_ready=1: in1 streams 0x10..0x17, in2 streams 0x20..0x27, both valid throughout:
   - required out order: 0x10-0x13, 0x20-0x23, 0x14-0x17, 0x24-0x27;
   - sel toggles every 4 transfers.
4. Backpressure: out_ready=0 for 5 cycles with out_valid=1 and out=0xDEADBEEF -> out stable, granted ready=0. On release, the next word follows with no loss or duplication (scoreboard).
5. Single streaming requester: only in2_valid, 10 words, MAX_BURST=4 -> 10 consecutive out_valid cycles, no bubble at the re-grant, sel=1 throughout.
6. Reset mid-burst: assert rst_n=0 after 2 of 4 burst words -> next cycle out_valid=0 and state=IDLE. After release with both valid, in1 is granted first.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 data mux between two
// valid/ready producers, with a per-grant burst limit to prevent starvation.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    burst_cnt_reg, burst_cnt_next;
    // 0 = in1 won last, 1 = in2 won last
    logic             last_winner_reg, last_winner_next;
    logic             sel_reg;
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;

    logic free, xfer1, xfer2, burst_done;

    function automatic state_t pick(input logic v1, input logic v2, input logic lw);
        state_t s;
        if (v1 && v2)
            s = lw ? G1 : G2;
        else if (v1)
            s = G1;
        else if (v2)
            s = G2;
        else
            s = IDLE;
        return s;
    endfunction

    assign free       = !out_valid_reg || out_ready;
    assign in1_ready  = (state_reg == G1) && free;
    assign in2_ready  = (state_reg == G2) && free;
    assign xfer1      = in1_valid && in1_ready;
    assign xfer2      = in2_valid && in2_ready;
    assign burst_done = (int'(burst_cnt_reg) + 1) >= MAX_BURST;

    always_comb begin
        state_next       = state_reg;
        burst_cnt_next   = burst_cnt_reg;
        last_winner_next = last_winner_reg;
        case (state_reg)
            IDLE: begin
                state_next     = pick(in1_valid, in2_valid, last_winner_reg);
                burst_cnt_next = '0;
            end
            G1: begin
                if (xfer1) begin
                    if (!burst_done) begin
                        burst_cnt_next = burst_cnt_reg + CW'(1);
                    end else begin
                        // Expiry hands over in the same cycle, so no bubble on a switch
                        last_winner_next = 1'b0;
                        burst_cnt_next   = '0;
                        state_next       = in2_valid ? G2 : G1;
                    end
                end else if (!in1_valid) begin
                    last_winner_next = 1'b0;
                    burst_cnt_next   = '0;
                    state_next       = pick(in1_valid, in2_valid, 1'b0);
                end
            end
            G2: begin
                if (xfer2) begin
                    if (!burst_done) begin
                        burst_cnt_next = burst_cnt_reg + CW'(1);
                    end else begin
                        last_winner_next = 1'b1;
                        burst_cnt_next   = '0;
                        state_next       = in1_valid ? G1 : G2;
                    end
                end else if (!in2_valid) begin
                    last_winner_next = 1'b1;
                    burst_cnt_next   = '0;
                    state_next       = pick(in1_valid, in2_valid, 1'b1);
                end
            end
            default: begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            burst_cnt_reg   <= '0;
            last_winner_reg <= 1'b1;
            sel_reg         <= 1'b0;
            out_reg         <= '0;
            out_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            burst_cnt_reg   <= burst_cnt_next;
            last_winner_reg <= last_winner_next;
            sel_reg         <= (state_next == G2);
            if (xfer1 || xfer2) begin
                out_reg       <= (state_reg == G2) ? in2 : in1;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign sel       = sel_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule
